// File: rtl/div_restoring_pkg.sv
// Shared definitions for the restoring divider: FSM encoding and the
// counter-width helper used to size the step counter.
package div_restoring_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Ceiling log2, minimum 1 so a counter always has at least one bit
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        if (result < 32'sd1) begin
            result = 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One combinational restoring step: shift in the next dividend bit, then
// subtract the divisor if it fits.
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_i,
    input  logic [W-1:0] divisor_i,
    input  logic         in_bit_i,
    output logic [W:0]   rem_o,
    output logic         q_bit_o
);

    logic [W:0] shifted_s;
    logic [W:0] diff_s;
    logic       fits_s;

    // rem_i[W] is zero in normal operation; if it were set the shifted value
    // would exceed any W-bit divisor, so it forces the subtract path.
    always_comb begin
        shifted_s = {rem_i[W-1:0], in_bit_i};
        diff_s    = shifted_s - {1'b0, divisor_i};
        fits_s    = rem_i[W] | (shifted_s >= {1'b0, divisor_i});
        if (fits_s) begin
            rem_o   = diff_s;
            q_bit_o = 1'b1;
        end else begin
            rem_o   = shifted_s;
            q_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/div_restoring.sv
// Unsigned sequential restoring divider resolving R quotient bits per
// enabled cycle, with a start/busy/done handshake and held results.
module div_restoring
    import div_restoring_pkg::*;
#(
    parameter int W = 32,
    parameter int R = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         ce_i,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o
);

    localparam int             STEPS    = W / R;
    localparam int             CW       = clog2(STEPS + 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(STEPS);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  dvd_r;
    logic [W-1:0]  dvs_r;
    logic [W:0]    rem_r;
    logic [W-1:0]  quotient_r;
    logic [W-1:0]  remainder_r;

    logic [W:0]    rem_chain_s [R+1];
    logic [R-1:0]  q_bits_s;
    logic [W-1:0]  dvd_next_s;

    assign rem_chain_s[0] = rem_r;

    // dvd_r shifts dividend bits out of the top while quotient bits enter at the bottom
    for (genvar i = 0; i < R; i++) begin : g_step
        div_step #(
            .W (W)
        ) u_step (
            .rem_i     (rem_chain_s[i]),
            .divisor_i (dvs_r),
            .in_bit_i  (dvd_r[W-1-i]),
            .rem_o     (rem_chain_s[i+1]),
            .q_bit_o   (q_bits_s[R-1-i])
        );
    end

    if (R == W) begin : g_full
        assign dvd_next_s = q_bits_s;
    end else begin : g_part
        assign dvd_next_s = {dvd_r[W-R-1:0], q_bits_s};
    end

    // FSM, step counter, operand/partial-remainder registers and result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            dvd_r       <= {W{1'b0}};
            dvs_r       <= {W{1'b0}};
            rem_r       <= {(W+1){1'b0}};
            quotient_r  <= {W{1'b0}};
            remainder_r <= {W{1'b0}};
        end else if (ce_i) begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        dvd_r   <= dividend_i;
                        dvs_r   <= divisor_i;
                        rem_r   <= {(W+1){1'b0}};
                        cnt_r   <= CNT_INIT;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    rem_r <= rem_chain_s[R];
                    dvd_r <= dvd_next_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        quotient_r  <= dvd_next_s;
                        remainder_r <= rem_chain_s[R][W-1:0];
                        state_r     <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign busy_o      = (state_r == ST_RUN);
    assign done_o      = (state_r == ST_DONE);
    assign quotient_o  = quotient_r;
    assign remainder_o = remainder_r;

endmodule

// File: tb/tb_div_restoring.sv
// Directed bench for div_restoring: four W=8 instances (R=1,2,4,8) sharing
// stimulus, checked against hand-computed quotients, remainders and timing.
module tb_div_restoring;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;

    logic       busy_a [4];
    logic       done_a [4];
    logic [7:0] q_a    [4];
    logic [7:0] r_a    [4];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    div_restoring #(.W(8), .R(1)) u_r1 (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .start_i(start),
        .dividend_i(dividend), .divisor_i(divisor),
        .busy_o(busy_a[0]), .done_o(done_a[0]), .quotient_o(q_a[0]), .remainder_o(r_a[0])
    );
    div_restoring #(.W(8), .R(2)) u_r2 (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .start_i(start),
        .dividend_i(dividend), .divisor_i(divisor),
        .busy_o(busy_a[1]), .done_o(done_a[1]), .quotient_o(q_a[1]), .remainder_o(r_a[1])
    );
    div_restoring #(.W(8), .R(4)) u_r4 (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .start_i(start),
        .dividend_i(dividend), .divisor_i(divisor),
        .busy_o(busy_a[2]), .done_o(done_a[2]), .quotient_o(q_a[2]), .remainder_o(r_a[2])
    );
    div_restoring #(.W(8), .R(8)) u_r8 (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .start_i(start),
        .dividend_i(dividend), .divisor_i(divisor),
        .busy_o(busy_a[3]), .done_o(done_a[3]), .quotient_o(q_a[3]), .remainder_o(r_a[3])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic check_zero_all(input string tag);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s_busy_r%0d", tag, 1 << d), {31'd0, busy_a[d]}, 32'd0);
            check($sformatf("%s_done_r%0d", tag, 1 << d), {31'd0, done_a[d]}, 32'd0);
            check($sformatf("%s_q_r%0d", tag, 1 << d), {24'd0, q_a[d]}, 32'd0);
            check($sformatf("%s_rem_r%0d", tag, 1 << d), {24'd0, r_a[d]}, 32'd0);
        end
    endtask

    // Called at k=1 (one cycle after the start edge); ends at k=9, the R=1 done cycle
    task automatic expect_all(input logic [7:0] eq, input logic [7:0] er,
                              input int pulse_k, input string tag);
        for (int k = 1; k <= 9; k++) begin
            for (int d = 0; d < 4; d++) begin
                int s;
                s = 8 >> d;
                check($sformatf("%s_busy_r%0d_k%0d", tag, 1 << d, k),
                      {31'd0, busy_a[d]}, (k <= s) ? 32'd1 : 32'd0);
                check($sformatf("%s_done_r%0d_k%0d", tag, 1 << d, k),
                      {31'd0, done_a[d]}, (k == s + 1) ? 32'd1 : 32'd0);
                if (k == s + 1) begin
                    check($sformatf("%s_q_r%0d", tag, 1 << d), {24'd0, q_a[d]}, {24'd0, eq});
                    check($sformatf("%s_rem_r%0d", tag, 1 << d), {24'd0, r_a[d]}, {24'd0, er});
                end
            end
            if (k < 9) begin
                if (k == pulse_k) begin
                    dividend = 8'd50;
                    divisor  = 8'd5;
                    start    = 1'b1;
                end
                step();
                start = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        ce       = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        #1;
        check_zero_all("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        launch(8'd100, 8'd7);
        expect_all(8'd14, 8'd2, 0, "d100_7");

        // start in the done cycle: accepted with no idle gap, old result held
        launch(8'd50, 8'd5);
        check("b2b_busy", {31'd0, busy_a[0]}, 32'd1);
        check("b2b_q_held", {24'd0, q_a[0]}, 32'd14);
        check("b2b_rem_held", {24'd0, r_a[0]}, 32'd2);
        expect_all(8'd10, 8'd0, 0, "b2b_50_5");

        launch(8'hA5, 8'd0);
        expect_all(8'hFF, 8'hA5, 0, "div0");
        launch(8'd3, 8'd200);
        expect_all(8'd0, 8'd3, 0, "d3_200");
        launch(8'd255, 8'd1);
        expect_all(8'd255, 8'd0, 0, "d255_1");
        launch(8'd200, 8'd9);
        expect_all(8'd22, 8'd2, 0, "d200_9");

        // start pulsed mid-run must be ignored
        launch(8'd100, 8'd7);
        expect_all(8'd14, 8'd2, 1, "ignore");

        // clock enable low for three cycles mid-run
        launch(8'd200, 8'd9);
        step();
        step();
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ce_frz_busy_%0d", i), {31'd0, busy_a[0]}, 32'd1);
            check($sformatf("ce_frz_done_%0d", i), {31'd0, done_a[0]}, 32'd0);
            step();
        end
        ce = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ce_run_busy_%0d", i), {31'd0, busy_a[0]}, 32'd1);
            check($sformatf("ce_run_done_%0d", i), {31'd0, done_a[0]}, 32'd0);
            step();
        end
        check("ce_done", {31'd0, done_a[0]}, 32'd1);
        check("ce_busy_low", {31'd0, busy_a[0]}, 32'd0);
        check("ce_q", {24'd0, q_a[0]}, 32'd22);
        check("ce_rem", {24'd0, r_a[0]}, 32'd2);

        // clock enable low while in DONE keeps done asserted
        ce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("ce_done_hold_%0d", i), {31'd0, done_a[0]}, 32'd1);
        end
        ce = 1'b1;
        step();
        check("ce_done_drop", {31'd0, done_a[0]}, 32'd0);
        check("ce_idle_busy", {31'd0, busy_a[0]}, 32'd0);
        check("ce_idle_q", {24'd0, q_a[0]}, 32'd22);

        // asynchronous reset mid-run
        launch(8'd100, 8'd7);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_all("async_rst");
        step();
        rst_n = 1'b1;
        step();
        launch(8'd100, 8'd7);
        expect_all(8'd14, 8'd2, 0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
